cbus_sched: RTL and testbench

Transaction scheduler for the 4-master core bus (cbus). It arbitrates master requests round-robin and holds each grant until the slave accepts with `m_ack`. It tags each issued command with the master's UID, counts outstanding reads per master (credit limit), and routes read responses back by `s_uid`. Its one-hot grants drive the cbus mux select.

---
 rtl/cbus_sched.sv | 176 +++++++++++++++++
 tb/tb_cbus_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_sched.sv
// cbus_sched: transaction scheduler for the 4-master core bus.
// It arbitrates master requests round-robin and holds each grant until the slave
// acknowledges it. It counts outstanding reads per master and refuses a reading
// master once that master reaches MAX_OUT outstanding reads. Read responses are
// routed back by UID. A per-grant watchdog drops a grant that is never acknowledged.
//
// Ports:
//   clk     - bus clock
//   rst     - asynchronous active-high reset
//   req     - per-master request, held until its grant is acked
//   req_rd  - per-master "pending command expects read data" (valid with req)
//   grnt    - registered one-hot (or zero) grant, drives the mux select
//   m_uid   - registered UID (index) of the granted master
//   m_ack   - slave accepted the granted command this cycle
//   s_rdy   - slave returning read data
//   s_uid   - UID of the returned data
//   s_sel   - combinational one-hot response route
//   idle    - no grant active and no outstanding reads
//   err_to  - sticky: a grant timed out
//   err_uid - sticky: a response arrived for a master with no outstanding reads
module cbus_sched #(
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned TO_CYC  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] req_rd,
    output logic [3:0] grnt,
    output logic [1:0] m_uid,
    input  logic       m_ack,
    input  logic       s_rdy,
    input  logic [1:0] s_uid,
    output logic [3:0] s_sel,
    output logic       idle,
    output logic       err_to,
    output logic       err_uid
);

    localparam logic [2:0] MaxOut = 3'(MAX_OUT);
    localparam logic [7:0] ToCyc  = 8'(TO_CYC);

    typedef enum logic [0:0] {StArb, StGnt} state_e;

    state_e     state_q, state_d;
    logic [3:0] grnt_q, grnt_d;
    logic [1:0] m_uid_q, m_uid_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] cnt_q [4];
    logic [2:0] cnt_d [4];
    logic [7:0] wdog_q, wdog_d;
    logic       err_to_q, err_to_d;
    logic       err_uid_q, err_uid_d;

    logic [3:0] elig;
    logic [3:0] inc;
    logic [3:0] dec;
    logic [2:0] win;

    // Returns {found, index} of the first set candidate starting at base.
    // Iterating downwards lets the lowest rotation offset overwrite the others.
    function automatic logic [2:0] pick(input logic [3:0] cand, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (cand[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Eligibility uses the registered counters only.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = req[i] & (~req_rd[i] | (cnt_q[i] < MaxOut));
        end
    end

    always_comb begin
        state_d  = state_q;
        grnt_d   = grnt_q;
        m_uid_d  = m_uid_q;
        ptr_d    = ptr_q;
        wdog_d   = wdog_q;
        err_to_d = err_to_q;
        inc      = '0;
        win      = '0;
        unique case (state_q)
            StArb: begin
                win = pick(elig, ptr_q);
                if (win[2]) begin
                    state_d = StGnt;
                    grnt_d  = 4'b0001 << win[1:0];
                    m_uid_d = win[1:0];
                    wdog_d  = '0;
                end
            end
            StGnt: begin
                if (m_ack) begin
                    inc[m_uid_q] = req_rd[m_uid_q];
                    ptr_d        = m_uid_q + 2'd1;
                    // The acked command is consumed, so the current owner is excluded.
                    win = pick(elig & ~grnt_q, m_uid_q + 2'd1);
                    if (win[2]) begin
                        grnt_d  = 4'b0001 << win[1:0];
                        m_uid_d = win[1:0];
                        wdog_d  = '0;
                    end else begin
                        state_d = StArb;
                        grnt_d  = '0;
                    end
                end else if (!req[m_uid_q]) begin
                    state_d = StArb;
                    grnt_d  = '0;
                end else if (wdog_q >= ToCyc) begin
                    state_d  = StArb;
                    grnt_d   = '0;
                    err_to_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d = StArb;
                grnt_d  = '0;
            end
        endcase
    end

    // Outstanding-read counters; a simultaneous issue and return cancel out.
    always_comb begin
        err_uid_d = err_uid_q;
        for (int i = 0; i < 4; i++) begin
            dec[i]   = s_rdy && (s_uid == 2'(i)) && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + 3'd1;
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end
        end
        if (s_rdy && (cnt_q[s_uid] == '0)) err_uid_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StArb;
            grnt_q    <= '0;
            m_uid_q   <= '0;
            ptr_q     <= '0;
            wdog_q    <= '0;
            err_to_q  <= 1'b0;
            err_uid_q <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            grnt_q    <= grnt_d;
            m_uid_q   <= m_uid_d;
            ptr_q     <= ptr_d;
            wdog_q    <= wdog_d;
            err_to_q  <= err_to_d;
            err_uid_q <= err_uid_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign grnt    = grnt_q;
    assign m_uid   = m_uid_q;
    assign s_sel   = s_rdy ? (4'b0001 << s_uid) : 4'b0000;
    assign idle    = (state_q == StArb) && (cnt_q[0] == '0) && (cnt_q[1] == '0) &&
                     (cnt_q[2] == '0) && (cnt_q[3] == '0);
    assign err_to  = err_to_q;
    assign err_uid = err_uid_q;

endmodule

// File: tb/tb_cbus_sched.sv
// Self-checking bench for cbus_sched: directed stimulus with literal expectations,
// plus a per-cycle comparison against a behavioural model of the scheduler.
module tb_cbus_sched;

    localparam int MAXO = 2;
    localparam int TO   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_rd;
    logic [3:0] grnt;
    logic [1:0] m_uid;
    logic       m_ack;
    logic       s_rdy;
    logic [1:0] s_uid;
    logic [3:0] s_sel;
    logic       idle;
    logic       err_to;
    logic       err_uid;

    int total = 0;
    int bad   = 0;

    cbus_sched #(
        .MAX_OUT(MAXO),
        .TO_CYC (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .req_rd (req_rd),
        .grnt   (grnt),
        .m_uid  (m_uid),
        .m_ack  (m_ack),
        .s_rdy  (s_rdy),
        .s_uid  (s_uid),
        .s_sel  (s_sel),
        .idle   (idle),
        .err_to (err_to),
        .err_uid(err_uid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_gnt: index of the master holding the grant, -1 when none.
    int m_gnt = -1;
    int m_uidx = 0;
    int m_ptr = 0;
    int m_wd = 0;
    int m_cnt [4] = '{0, 0, 0, 0};
    bit m_eto = 1'b0;
    bit m_euid = 1'b0;

    function automatic bit elig(int i);
        return req[i] && (!req_rd[i] || m_cnt[i] < MAXO);
    endfunction

    // First eligible master in priority order base, base+1, ... skipping excl.
    function automatic int pick(int base, int excl);
        int j;
        for (int k = 0; k < 4; k++) begin
            j = (base + k) % 4;
            if (j != excl && elig(j)) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : mdl
        int g, w, ng, nuid, nptr, nwd;
        int nc [4];
        bit neto, neuid;
        if (rst) begin
            m_gnt  <= -1;
            m_uidx <= 0;
            m_ptr  <= 0;
            m_wd   <= 0;
            m_cnt  <= '{0, 0, 0, 0};
            m_eto  <= 1'b0;
            m_euid <= 1'b0;
        end else begin
            ng = m_gnt; nuid = m_uidx; nptr = m_ptr; nwd = m_wd;
            nc = m_cnt; neto = m_eto; neuid = m_euid;
            if (s_rdy) begin
                if (m_cnt[s_uid] == 0) neuid = 1'b1;
                else nc[s_uid] = nc[s_uid] - 1;
            end
            if (m_gnt < 0) begin
                w = pick(m_ptr, -1);
                if (w >= 0) begin ng = w; nuid = w; nwd = 0; end
            end else begin
                g = m_gnt;
                if (m_ack) begin
                    if (req_rd[g]) nc[g] = nc[g] + 1;
                    nptr = (g + 1) % 4;
                    w = pick(nptr, g);
                    ng = w;
                    if (w >= 0) begin nuid = w; nwd = 0; end
                end else if (!req[g]) begin
                    ng = -1;
                end else if (m_wd == TO) begin
                    ng = -1;
                    neto = 1'b1;
                end else begin
                    nwd = m_wd + 1;
                end
            end
            m_gnt  <= ng;
            m_uidx <= nuid;
            m_ptr  <= nptr;
            m_wd   <= nwd;
            m_cnt  <= nc;
            m_eto  <= neto;
            m_euid <= neuid;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit all_zero;
        all_zero = (m_cnt[0] == 0) && (m_cnt[1] == 0) && (m_cnt[2] == 0) && (m_cnt[3] == 0);
        chk("mdl_grnt", 32'(grnt), (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
        if (m_gnt >= 0) chk("mdl_m_uid", 32'(m_uid), 32'(m_uidx));
        chk("mdl_idle", 32'(idle), 32'((m_gnt < 0) && all_zero));
        chk("mdl_err_to", 32'(err_to), 32'(m_eto));
        chk("mdl_err_uid", 32'(err_uid), 32'(m_euid));
        chk("mdl_s_sel", 32'(s_sel), s_rdy ? (32'd1 << s_uid) : 32'd0);
    end

    // ---------------- directed stimulus ----------------
    // One bus cycle: drive inputs just after the edge, leave 1 time unit to settle.
    task automatic step(input logic [3:0] rq, input logic [3:0] rd, input logic ack,
                        input logic sr, input logic [1:0] su);
        @(posedge clk);
        #1;
        req = rq; req_rd = rd; m_ack = ack; s_rdy = sr; s_uid = su;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_rd = '0; m_ack = 1'b0; s_rdy = 1'b0; s_uid = '0;
        @(posedge clk);
        #2;
        chk("rst_grnt", 32'(grnt), 32'd0);
        chk("rst_m_uid", 32'(m_uid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_errs", 32'({err_to, err_uid}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Rotation: write-only requests from all masters, ack every grant.
        step(4'hf, 4'h0, 1'b0, 1'b0, 2'd0);
        step(4'hf, 4'h0, 1'b1, 1'b0, 2'd0); chk("rot_g0", 32'(grnt), 32'h1);
        chk("rot_uid0", 32'(m_uid), 32'd0);
        step(4'hf, 4'h0, 1'b1, 1'b0, 2'd0); chk("rot_g1", 32'(grnt), 32'h2);
        chk("rot_uid1", 32'(m_uid), 32'd1);
        step(4'hf, 4'h0, 1'b1, 1'b0, 2'd0); chk("rot_g2", 32'(grnt), 32'h4);
        step(4'hf, 4'h0, 1'b1, 1'b0, 2'd0); chk("rot_g3", 32'(grnt), 32'h8);
        chk("rot_uid3", 32'(m_uid), 32'd3);
        step(4'h0, 4'h0, 1'b1, 1'b0, 2'd0); chk("rot_g0b", 32'(grnt), 32'h1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("rot_end", 32'(grnt), 32'h0);
        chk("rot_idle", 32'(idle), 32'd1);

        // Credit limit: master 1 reads only, MAX_OUT = 2.
        step(4'h2, 4'h2, 1'b0, 1'b0, 2'd0);
        step(4'h2, 4'h2, 1'b1, 1'b0, 2'd0); chk("cr_g1", 32'(grnt), 32'h2);
        step(4'h2, 4'h2, 1'b1, 1'b0, 2'd0); chk("cr_gap", 32'(grnt), 32'h0);
        step(4'h2, 4'h2, 1'b1, 1'b0, 2'd0); chk("cr_g2", 32'(grnt), 32'h2);
        step(4'h2, 4'h2, 1'b1, 1'b0, 2'd0); chk("cr_full", 32'(grnt), 32'h0);
        step(4'h2, 4'h2, 1'b1, 1'b1, 2'd1); chk("cr_full2", 32'(grnt), 32'h0);
        chk("cr_s_sel", 32'(s_sel), 32'h2);
        step(4'h2, 4'h2, 1'b1, 1'b0, 2'd0); chk("cr_wait", 32'(grnt), 32'h0);
        step(4'h2, 4'h2, 1'b1, 1'b0, 2'd0); chk("cr_regrant", 32'(grnt), 32'h2);
        step(4'h0, 4'h0, 1'b0, 1'b1, 2'd1); chk("cr_drop", 32'(grnt), 32'h0);
        chk("cr_busy", 32'(idle), 32'd0);
        step(4'h0, 4'h0, 1'b0, 1'b1, 2'd1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("cr_idle", 32'(idle), 32'd1);
        chk("cr_no_uid_err", 32'(err_uid), 32'd0);

        // Abort: pointer sits at 2; abort must not advance it.
        step(4'h4, 4'h0, 1'b0, 1'b0, 2'd0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("ab_g2", 32'(grnt), 32'h4);
        step(4'h5, 4'h0, 1'b0, 1'b0, 2'd0); chk("ab_clear", 32'(grnt), 32'h0);
        step(4'h5, 4'h0, 1'b1, 1'b0, 2'd0); chk("ab_ptr", 32'(grnt), 32'h4);
        step(4'h0, 4'h0, 1'b1, 1'b0, 2'd0); chk("ab_b2b", 32'(grnt), 32'h1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("ab_end", 32'(grnt), 32'h0);

        // Timeout: pointer at 1, master 3 granted and never acked.
        step(4'h8, 4'h0, 1'b0, 1'b0, 2'd0);
        step(4'h8, 4'h0, 1'b0, 1'b0, 2'd0); chk("to_g3", 32'(grnt), 32'h8);
        step(4'h8, 4'h0, 1'b0, 1'b0, 2'd0);
        step(4'h8, 4'h0, 1'b0, 1'b0, 2'd0);
        step(4'h8, 4'h0, 1'b0, 1'b0, 2'd0);
        step(4'h8, 4'h0, 1'b0, 1'b0, 2'd0); chk("to_hold", 32'(grnt), 32'h8);
        chk("to_noerr", 32'(err_to), 32'd0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("to_drop", 32'(grnt), 32'h0);
        chk("to_err", 32'(err_to), 32'd1);
        step(4'h9, 4'h0, 1'b0, 1'b0, 2'd0);
        step(4'h9, 4'h0, 1'b1, 1'b0, 2'd0); chk("to_ptr", 32'(grnt), 32'h8);
        step(4'h0, 4'h0, 1'b1, 1'b0, 2'd0); chk("to_b2b", 32'(grnt), 32'h1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("to_sticky", 32'(err_to), 32'd1);

        // Simultaneous issue/return on master 0, then a spurious response.
        step(4'h1, 4'h1, 1'b0, 1'b0, 2'd0);
        step(4'h1, 4'h1, 1'b1, 1'b0, 2'd0); chk("sim_g0", 32'(grnt), 32'h1);
        step(4'h1, 4'h1, 1'b1, 1'b0, 2'd0); chk("sim_gap", 32'(grnt), 32'h0);
        step(4'h1, 4'h1, 1'b1, 1'b1, 2'd0); chk("sim_g0b", 32'(grnt), 32'h1);
        chk("sim_s_sel", 32'(s_sel), 32'h1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("sim_busy", 32'(idle), 32'd0);
        step(4'h0, 4'h0, 1'b0, 1'b1, 2'd0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("sim_idle", 32'(idle), 32'd1);
        chk("sim_no_uid_err", 32'(err_uid), 32'd0);
        step(4'h0, 4'h0, 1'b0, 1'b1, 2'd2); chk("sp_s_sel", 32'(s_sel), 32'h4);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("sp_err", 32'(err_uid), 32'd1);
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("sp_sticky", 32'(err_uid), 32'd1);

        // Asynchronous reset in the middle of a grant.
        step(4'h2, 4'h0, 1'b0, 1'b0, 2'd0);
        step(4'h2, 4'h0, 1'b0, 1'b0, 2'd0); chk("ar_g1", 32'(grnt), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("ar_grnt", 32'(grnt), 32'h0);
        chk("ar_idle", 32'(idle), 32'd1);
        chk("ar_errs", 32'({err_to, err_uid}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = '0;
        step(4'h0, 4'h0, 1'b0, 1'b0, 2'd0); chk("ar_after", 32'(idle), 32'd1);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
